xor_rr_sched: RTL and testbench

- Round-robin scheduler that shares one 19-bit XOR datapath (out = a ^ b, bitwise) between NREQ requesters. Typical requesters are the decoder's syndrome and parity-check stages.
- Each requester presents an operand pair with valid/ready. The block grants one requester per cycle and registers the XOR result with the winner's ID and a zero-syndrome flag.
- The result leaves on a valid/ready output port with a 1-entry output register. A saturating operation counter supports performance checks.

---
 rtl/xor_sched_pkg.sv | 23 ++
 rtl/xor_rr_sched_rr_grant.sv | 34 +++
 rtl/xor_rr_sched.sv | 91 +++++++++
 tb/tb_xor_rr_sched.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/xor_sched_pkg.sv
// Shared constants and helpers for the round-robin XOR scheduler.
package xor_sched_pkg;

    localparam int WIDTH_DEF = 19;
    localparam int NREQ_DEF  = 4;
    localparam int CNTW_DEF  = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    // Ceiling log2, never less than 1 so a 2-requester build still gets an ID bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int unsigned i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = int'(i) + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/xor_rr_sched_rr_grant.sv
// Rotate-priority encoder: first set request at or after ptr_i, wrapping.
module rr_grant
    import xor_sched_pkg::*;
#(
    parameter int   NREQ = NREQ_DEF,
    localparam int  IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_req_o
);

    logic        found;
    int unsigned cand;

    always_comb begin
        grant_o   = '0;
        idx_o     = '0;
        any_req_o = |req_i;
        found     = 1'b0;
        cand      = 0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = (32'(ptr_i) + off) % NREQ;
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/xor_rr_sched.sv
// Round-robin scheduler sharing one XOR datapath between NREQ requesters,
// with a 1-entry pass-through output register and a saturating op counter.
module xor_rr_sched
    import xor_sched_pkg::*;
#(
    parameter int  WIDTH = WIDTH_DEF,
    parameter int  NREQ  = NREQ_DEF,
    parameter int  CNTW  = CNTW_DEF,
    localparam int IDW   = clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [IDW-1:0]    out_id,
    output logic              out_zero,
    output logic [CNTW-1:0]   op_count
);

    slot_e             state_q, state_d;
    logic [WIDTH-1:0]  data_q;
    logic [IDW-1:0]    id_q;
    logic              zero_q;
    logic [CNTW-1:0]   cnt_q;
    logic [IDW-1:0]    ptr_q;

    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    gidx;
    logic              any_req;
    logic              can_accept;
    logic              accept;
    logic [WIDTH-1:0]  sel_a, sel_b;

    rr_grant #(.NREQ(NREQ)) u_grant (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .grant_o   (grant),
        .idx_o     (gidx),
        .any_req_o (any_req)
    );

    assign can_accept = (state_q == SLOT_EMPTY) || out_ready;
    assign req_ready  = (reset || !can_accept || !any_req) ? '0 : grant;
    assign accept     = |req_ready;

    always_comb begin
        sel_a = req_a[32'(gidx)*WIDTH +: WIDTH];
        sel_b = req_b[32'(gidx)*WIDTH +: WIDTH];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
            SLOT_FULL:  if (!accept && out_ready) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= sel_a ^ sel_b;
                id_q   <= gidx;
                zero_q <= (sel_a == sel_b);
                ptr_q  <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + IDW'(1);
                if (cnt_q != '1) cnt_q <= cnt_q + CNTW'(1);
            end
        end
    end

    assign out_valid = (state_q == SLOT_FULL);
    assign out_data  = data_q;
    assign out_id    = id_q;
    assign out_zero  = zero_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_xor_rr_sched.sv
// Randomised + directed bench for xor_rr_sched against a behavioural model.
module tb_xor_rr_sched;
    import xor_sched_pkg::*;

    localparam int W  = 19;
    localparam int N  = 4;
    localparam int C  = 6;
    localparam int IW = 2;
    localparam int CMAX = (1 << C) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*W-1:0]    req_a, req_b;
    logic [N-1:0]      req_ready;
    logic              out_valid, out_ready, out_zero;
    logic [W-1:0]      out_data;
    logic [IW-1:0]     out_id;
    logic [C-1:0]      op_count;

    always #5 clk = ~clk;

    xor_rr_sched #(.WIDTH(W), .NREQ(N), .CNTW(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_zero  (out_zero),
        .op_count  (op_count)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model: slot contents, priority pointer and counter as plain ints.
    bit         m_valid = 0;
    bit         m_zero  = 0;
    logic [W-1:0] m_data = '0;
    int         m_id  = 0;
    int         m_ptr = 0;
    int         m_cnt = 0;
    logic [N-1:0] seen_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic rand_ops();
        logic [W-1:0] a, b;
        for (int i = 0; i < N; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
            set_ops(i, a, b);
        end
    endtask

    // One clock cycle: drive, check grant vs model, clock, advance model, check outputs.
    task automatic step(input logic rst, input logic [N-1:0] v, input logic ordy);
        int g, c;
        logic [W-1:0] a, b;
        logic [N-1:0] exp_r;
        reset     = rst;
        req_valid = v;
        out_ready = ordy;
        #2;
        g = -1;
        if (!rst && (!m_valid || ordy)) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (g < 0 && v[c]) g = c;
            end
        end
        exp_r = (g < 0) ? '0 : N'(1 << g);
        seen_ready = req_ready;
        chk("req_ready", 64'(req_ready), 64'(exp_r));
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_data = '0; m_id = 0; m_zero = 0; m_cnt = 0; m_ptr = 0;
        end else if (g >= 0) begin
            a = req_a[g*W +: W];
            b = req_b[g*W +: W];
            m_valid = 1;
            m_data  = a ^ b;
            m_id    = g;
            m_zero  = (a == b);
            m_ptr   = (g + 1) % N;
            if (m_cnt < CMAX) m_cnt++;
        end else if (ordy) begin
            m_valid = 0;
        end
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("out_data",  64'(out_data),  64'(m_data));
        chk("out_id",    64'(out_id),    64'(m_id));
        chk("out_zero",  64'(out_zero),  64'(m_zero));
        chk("op_count",  64'(op_count),  64'(m_cnt));
    endtask

    initial begin
        req_a = '0;
        req_b = '0;

        // Reset then idle
        step(1, 4'b0000, 1);
        step(1, 4'b0000, 1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(op_count), 64'd0);
        step(0, 4'b0000, 1);
        chk("idle_ready", 64'(seen_ready), 64'd0);

        // Single op on requester 2
        set_ops(2, 19'h7FFFF, 19'h00001);
        step(0, 4'b0100, 1);
        chk("single_ready", 64'(seen_ready), 64'b0100);
        chk("single_data", 64'(out_data), 64'h7FFFE);
        chk("single_id", 64'(out_id), 64'd2);
        chk("single_zero", 64'(out_zero), 64'd0);
        chk("single_cnt", 64'(op_count), 64'd1);

        // Equal operands on requester 0 (pointer wraps 3 -> 0)
        set_ops(0, 19'h2AAAA, 19'h2AAAA);
        step(0, 4'b0001, 1);
        chk("eq_ready", 64'(seen_ready), 64'b0001);
        chk("eq_data", 64'(out_data), 64'd0);
        chk("eq_zero", 64'(out_zero), 64'd1);
        chk("eq_cnt", 64'(op_count), 64'd2);

        // All requesters valid: strict rotation, one result per cycle
        step(1, 4'b0000, 1);
        for (int k = 0; k < 8; k++) begin
            rand_ops();
            step(0, 4'b1111, 1);
            chk("rr_order", 64'(seen_ready), 64'(1 << (k % 4)));
            chk("rr_id", 64'(out_id), 64'(k % 4));
            chk("rr_cnt", 64'(op_count), 64'(k + 1));
        end

        // Backpressure with pointer at 1
        step(0, 4'b0000, 1);
        set_ops(0, 19'h12345, 19'h0F0F0);
        step(0, 4'b0001, 0);
        set_ops(1, 19'h11111, 19'h22222);
        set_ops(3, 19'h33333, 19'h44444);
        for (int k = 0; k < 3; k++) begin
            step(0, 4'b1010, 0);
            chk("bp_ready", 64'(seen_ready), 64'd0);
            chk("bp_data", 64'(out_data), 64'(19'h12345 ^ 19'h0F0F0));
            chk("bp_id", 64'(out_id), 64'd0);
        end
        step(0, 4'b1010, 1);
        chk("bp_release", 64'(seen_ready), 64'b0010);
        chk("bp_rel_id", 64'(out_id), 64'd1);
        chk("bp_rel_data", 64'(out_data), 64'(19'h11111 ^ 19'h22222));

        // Reset while full and stalled
        step(0, 4'b1010, 0);
        step(1, 4'b1010, 0);
        chk("rst_mid_ready", 64'(seen_ready), 64'd0);
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_cnt", 64'(op_count), 64'd0);
        step(0, 4'b1001, 1);
        chk("rst_first_grant", 64'(seen_ready), 64'b0001);

        // Randomised traffic
        for (int k = 0; k < 300; k++) begin
            rand_ops();
            step(logic'($urandom_range(0, 99) == 0), N'($urandom),
                 logic'($urandom_range(0, 9) < 7));
        end

        // Counter saturation
        step(1, 4'b0000, 1);
        for (int k = 0; k < CMAX + 10; k++) begin
            rand_ops();
            step(0, 4'b1111, 1);
        end
        chk("cnt_sat", 64'(op_count), 64'(CMAX));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
